// File: rtl/rv_core_pkg.sv
// Shared core definitions: fetch FSM states, base opcodes and the canonical NOP.
package rv_core_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC target selection for a retiring instruction plus word-alignment check.
module next_pc_sel #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic            branch_i,
  input  logic            branch_taken_i,
  input  logic            jump_i,
  input  logic            jumpback_i,
  output logic [XLEN-1:0] target_c_o,
  output logic            misalign_c_o
);

  // JALR clears bit0 of the sum; PC-relative targets share one adder.
  always_comb begin
    target_c_o = pc_i + XLEN'(4);
    if (jumpback_i) begin
      target_c_o = (rs1_val_i + imm_i) & {{(XLEN-1){1'b1}}, 1'b0};
    end else if (jump_i || (branch_i && branch_taken_i)) begin
      target_c_o = pc_i + imm_i;
    end
    misalign_c_o = |target_c_o[1:0];
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns the PC, handshakes with imem and hands one instruction at a time to decode.
module pc_fetch_unit
  import rv_core_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int unsigned     IMEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [6:0]         opcode,
  output logic [2:0]         funct3,
  output logic [6:0]         funct7,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus4,
  input  logic               instr_ack,
  input  logic               branch,
  input  logic               branch_taken,
  input  logic               jump,
  input  logic               jumpback,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    rs1_val,
  output logic               fetch_err,
  output logic               misalign_err
);

  localparam int unsigned CNT_W = 8;

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [XLEN-1:0]    pc_plus4_q;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fetch_err_q, fetch_err_d;
  logic               misalign_err_q, misalign_err_d;
  logic               imem_req_q, instr_valid_q;
  logic [XLEN-1:0]    target_c;
  logic               misalign_c;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .pc_i           (pc_q),
    .imm_i          (imm),
    .rs1_val_i      (rs1_val),
    .branch_i       (branch),
    .branch_taken_i (branch_taken),
    .jump_i         (jump),
    .jumpback_i     (jumpback),
    .target_c_o     (target_c),
    .misalign_c_o   (misalign_c)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    cnt_d          = cnt_q;
    fetch_err_d    = fetch_err_q;
    misalign_err_d = misalign_err_q;
    case (state_q)
      ST_BOOT: begin
        cnt_d   = '0;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = ST_ISSUE;
        end else if (cnt_q == CNT_W'(IMEM_TIMEOUT - 1)) begin
          fetch_err_d = 1'b1;
          state_d     = ST_HALT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ISSUE: begin
        // A misaligned target halts without disturbing the PC of the offending instruction.
        if (instr_ack) begin
          if (misalign_c) begin
            misalign_err_d = 1'b1;
            state_d        = ST_HALT;
          end else begin
            pc_d    = target_c;
            cnt_d   = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_PC;
      pc_plus4_q     <= RESET_PC + XLEN'(4);
      instr_q        <= NOP_INSTR;
      cnt_q          <= '0;
      fetch_err_q    <= 1'b0;
      misalign_err_q <= 1'b0;
      imem_req_q     <= 1'b0;
      instr_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pc_plus4_q     <= pc_d + XLEN'(4);
      instr_q        <= instr_d;
      cnt_q          <= cnt_d;
      fetch_err_q    <= fetch_err_d;
      misalign_err_q <= misalign_err_d;
      imem_req_q     <= (state_d == ST_FETCH);
      instr_valid_q  <= (state_d == ST_ISSUE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && (state_q == ST_ISSUE) && instr_ack) begin
      assert (!(jump && jumpback)) else $error("jump and jumpback retired together");
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign opcode       = instr_q[6:0];
  assign rd           = instr_q[11:7];
  assign funct3       = instr_q[14:12];
  assign rs1          = instr_q[19:15];
  assign rs2          = instr_q[24:20];
  assign funct7       = instr_q[31:25];
  assign pc           = pc_q;
  assign pc_plus4     = pc_plus4_q;
  assign fetch_err    = fetch_err_q;
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized bench for pc_fetch_unit against a PC-level reference model.
module tb_pc_fetch_unit;
  import rv_core_pkg::*;

  localparam int unsigned     XLEN         = 32;
  localparam logic [XLEN-1:0] RESET_PC     = 32'h0000_0000;
  localparam int unsigned     IMEM_TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic            instr_valid;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] pc, pc_plus4;
  logic            instr_ack, branch, branch_taken, jump, jumpback;
  logic [XLEN-1:0] imm, rs1_val;
  logic            fetch_err, misalign_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] m_pc;

  pc_fetch_unit #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .IMEM_TIMEOUT(IMEM_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2),
    .pc(pc), .pc_plus4(pc_plus4),
    .instr_ack(instr_ack), .branch(branch), .branch_taken(branch_taken),
    .jump(jump), .jumpback(jumpback), .imm(imm), .rs1_val(rs1_val),
    .fetch_err(fetch_err), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [7];
    logic [31:0] r;
    opcs = '{OPC_RTYPE, OPC_LOAD, OPC_STORE, OPC_ITYPE, OPC_BRANCH, OPC_JAL, OPC_JALR};
    r = $urandom;
    return {r[31:7], opcs[$urandom_range(0, 6)]};
  endfunction

  // Wait for a request, answer after lat idle cycles, then check what decode sees.
  task automatic do_fetch(input logic [31:0] data, input int unsigned lat);
    int unsigned waited;
    waited = 0;
    while (imem_req !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check("req_seen", 32'(imem_req), 32'd1);
    check("imem_addr", imem_addr, m_pc);
    for (int i = 0; i < int'(lat); i++) tick();
    imem_ready = 1'b1;
    imem_rdata = data;
    tick();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    check("valid_after_ready", 32'(instr_valid), 32'd1);
    check("req_dropped", 32'(imem_req), 32'd0);
    check("instr", instr, data);
    check("fields", {funct7, rs2, rs1, funct3, rd, opcode}, data);
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
  endtask

  // One cycle of unacked redirect noise, then the real retirement; model predicts the outcome.
  task automatic do_retire(input logic b, input logic t, input logic j, input logic jb,
                           input logic [31:0] im, input logic [31:0] rs);
    logic [31:0] tgt;
    logic [3:0]  noise;
    noise = 4'($urandom);
    {branch, branch_taken, jump, jumpback} = noise;
    imm = $urandom;
    rs1_val = $urandom;
    tick();
    check("hold_valid", 32'(instr_valid), 32'd1);
    check("hold_pc", pc, m_pc);
    {branch, branch_taken, jump, jumpback} = {b, t, j, jb};
    imm = im;
    rs1_val = rs;
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    {branch, branch_taken, jump, jumpback} = 4'b0000;
    if (jb) tgt = (rs + im) & 32'hFFFF_FFFE;
    else if (j || (b && t)) tgt = m_pc + im;
    else tgt = m_pc + 32'd4;
    check("valid_after_ack", 32'(instr_valid), 32'd0);
    if (tgt[1:0] != 2'b00) begin
      check("misalign_set", 32'(misalign_err), 32'd1);
      check("halt_no_req", 32'(imem_req), 32'd0);
      check("halt_pc_frozen", pc, m_pc);
    end else begin
      m_pc = tgt;
      check("no_misalign", 32'(misalign_err), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] im, rs;
    int unsigned kind;
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0; instr_ack = 1'b0;
    branch = 1'b0; branch_taken = 1'b0; jump = 1'b0; jumpback = 1'b0;
    imm = '0; rs1_val = '0;
    m_pc = RESET_PC;
    tick(); tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, NOP_INSTR);
    check("rst_pc", pc, RESET_PC);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    rst_n = 1'b1;

    // First instruction with same-cycle ready, then sequential retire.
    do_fetch(32'h0010_0093, 0);
    check("first_opcode", 32'(opcode), 32'(OPC_ITYPE));
    check("first_rd", 32'(rd), 32'd1);
    check("first_pc_plus4", pc_plus4, 32'd4);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("seq_addr", imem_addr, 32'h4);

    do_fetch(rand_instr(), 1);
    do_retire(1'b0, 1'b0, 1'b1, 1'b0, 32'h1C, 32'd0);
    do_fetch(rand_instr(), 2);
    check("at_0x20", pc, 32'h20);
    do_retire(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0);
    check("br_taken_addr", imem_addr, 32'h18);
    do_fetch(rand_instr(), 0);
    do_retire(1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'd0);
    do_fetch(rand_instr(), 3);
    do_retire(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'd0);
    check("br_not_taken_addr", imem_addr, 32'h24);

    // Randomized traffic with aligned targets.
    for (int n = 0; n < 40; n++) begin
      do_fetch(rand_instr(), $urandom_range(0, 4));
      im = ($urandom_range(0, 511) - 256) * 4;
      rs = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      kind = $urandom_range(0, 4);
      case (kind)
        0: do_retire(1'b0, 1'($urandom), 1'b0, 1'b0, im, rs);
        1: do_retire(1'b1, 1'b1, 1'b0, 1'b0, im, rs);
        2: do_retire(1'b1, 1'b0, 1'b0, 1'b0, im, rs);
        3: do_retire(1'($urandom), 1'($urandom), 1'b1, 1'b0, im, rs);
        default: do_retire(1'($urandom), 1'($urandom), 1'b0, 1'b1, im, rs);
      endcase
    end

    // JALR to 0x40, then 0x101+0x10 -> 0x110, then misaligned 0x112.
    do_fetch(rand_instr(), 1);
    do_retire(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h40);
    do_fetch(rand_instr(), 0);
    check("at_0x40", pc, 32'h40);
    do_retire(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h101);
    check("jalr_addr", imem_addr, 32'h110);
    do_fetch(rand_instr(), 0);
    do_retire(1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 32'h103);
    imem_ready = 1'b1;
    tick(); tick(); tick();
    imem_ready = 1'b0;
    check("halt_req_stays_low", 32'(imem_req), 32'd0);
    check("halt_valid_low", 32'(instr_valid), 32'd0);
    check("halt_misalign_sticky", 32'(misalign_err), 32'd1);
    check("halt_pc_0x110", pc, 32'h110);

    // Timeout: exactly IMEM_TIMEOUT waiting cycles.
    rst_n = 1'b0;
    tick();
    check("rst_clears_misalign", 32'(misalign_err), 32'd0);
    rst_n = 1'b1;
    m_pc = RESET_PC;
    tick();
    check("to_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < int'(IMEM_TIMEOUT) - 1; i++) tick();
    check("to_not_yet", 32'(fetch_err), 32'd0);
    check("to_still_req", 32'(imem_req), 32'd1);
    tick();
    check("to_fetch_err", 32'(fetch_err), 32'd1);
    check("to_req_low", 32'(imem_req), 32'd0);
    check("to_valid_low", 32'(instr_valid), 32'd0);
    rst_n = 1'b0;
    tick();
    check("rst_clears_fetch_err", 32'(fetch_err), 32'd0);
    check("rst_restart_addr", imem_addr, RESET_PC);
    rst_n = 1'b1;
    tick();
    check("restart_req", 32'(imem_req), 32'd1);

    // Reset during FETCH with a response in the same cycle.
    rst_n = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ready = 1'b0;
    check("midrst_instr_nop", instr, NOP_INSTR);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    check("midrst_req", 32'(imem_req), 32'd0);
    rst_n = 1'b1;
    tick();
    check("boot_one_cycle", 32'(imem_req), 32'd1);

    // PC wrap from 0xFFFF_FFFC to 0.
    m_pc = RESET_PC;
    do_fetch(rand_instr(), 0);
    do_retire(1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'd0);
    do_fetch(rand_instr(), 1);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    do_retire(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_no_fetch_err", 32'(fetch_err), 32'd0);
    check("wrap_no_misalign", 32'(misalign_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
